// File: rtl/laser_pkg.sv
`default_nettype none
// ============================================================================
// Module : laser_pkg
// Brief  : Shared types and constants for the two-circle laser placement
//          scheduler: FSM state encoding, grid coordinate type, grid and
//          window limits, plus window-bound helpers.
// Rev    : 1.0  initial release
// ============================================================================
package laser_pkg;

  localparam int GRID_MAX = 15;
  localparam int WIN_R    = 4;

  typedef logic [3:0] coord_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SWEEP = 3'd1,
    S_EVAL  = 3'd2,
    S_ROUND = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  localparam coord_t c_grid_max = coord_t'(GRID_MAX);
  localparam coord_t c_win_r    = coord_t'(WIN_R);

  // Lower window edge about a centre, clamped at the grid origin.
  function automatic coord_t win_lo(input coord_t c);
    return (c < c_win_r) ? '0 : coord_t'(c - c_win_r);
  endfunction

  // Upper window edge about a centre, clamped at the grid edge.
  function automatic coord_t win_hi(input coord_t c);
    return (c > coord_t'(c_grid_max - c_win_r)) ? c_grid_max : coord_t'(c + c_win_r);
  endfunction

endpackage
`default_nettype wire

// File: rtl/laser_sched_if.sv
`default_nettype none
// ============================================================================
// Module : laser_sched_if
// Brief  : Control, coverage-engine handshake and result bus of laser_sched.
//          master = scheduler side, slave = engine / host side.
// Rev    : 1.0  initial release
// ============================================================================
interface laser_sched_if;
  import laser_pkg::*;

  logic       START;
  logic       REQ;
  coord_t     CAND_X;
  coord_t     CAND_Y;
  logic       WHICH;
  logic       ACK;
  logic [5:0] CNT;
  coord_t     C1X;
  coord_t     C1Y;
  coord_t     C2X;
  coord_t     C2Y;
  logic       BUSY;
  logic       DONE;

  modport master (
    input  START, ACK, CNT,
    output REQ, CAND_X, CAND_Y, WHICH, C1X, C1Y, C2X, C2Y, BUSY, DONE
  );

  modport slave (
    output START, ACK, CNT,
    input  REQ, CAND_X, CAND_Y, WHICH, C1X, C1Y, C2X, C2Y, BUSY, DONE
  );

endinterface
`default_nettype wire

// File: rtl/laser_sweep_gen.sv
`default_nettype none
// ============================================================================
// Module : laser_sweep_gen
// Brief  : Candidate generator for one sweep phase. Captures the x/y bounds
//          at phase load (full grid or a clamped window about a centre),
//          steps x inner / y outer, and flags the last candidate.
// Rev    : 1.0  initial release
// ============================================================================
module laser_sweep_gen
  import laser_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load_i,
  input  logic   win_i,
  input  logic   step_i,
  input  coord_t cx_i,
  input  coord_t cy_i,
  output coord_t x_o,
  output coord_t y_o,
  output logic   last_o
);

  coord_t xlo_q, xlo_d, xhi_q, xhi_d;
  coord_t ylo_q, ylo_d, yhi_q, yhi_d;
  coord_t x_q, x_d, y_q, y_d;

  // Next bounds/candidate: load restarts the phase, step walks the raster.
  always_comb begin
    xlo_d = xlo_q;
    xhi_d = xhi_q;
    ylo_d = ylo_q;
    yhi_d = yhi_q;
    x_d   = x_q;
    y_d   = y_q;
    if (load_i) begin
      if (win_i) begin
        xlo_d = win_lo(cx_i);
        xhi_d = win_hi(cx_i);
        ylo_d = win_lo(cy_i);
        yhi_d = win_hi(cy_i);
      end else begin
        xlo_d = '0;
        xhi_d = c_grid_max;
        ylo_d = '0;
        yhi_d = c_grid_max;
      end
      x_d = xlo_d;
      y_d = ylo_d;
    end else if (step_i) begin
      if (x_q == xhi_q) begin
        x_d = xlo_q;
        y_d = y_q + 4'd1;
      end else begin
        x_d = x_q + 4'd1;
      end
    end
  end

  // Bound and candidate registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xlo_q <= '0;
      xhi_q <= '0;
      ylo_q <= '0;
      yhi_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
    end else begin
      xlo_q <= xlo_d;
      xhi_q <= xhi_d;
      ylo_q <= ylo_d;
      yhi_q <= yhi_d;
      x_q   <= x_d;
      y_q   <= y_d;
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign last_o = (x_q == xhi_q) && (y_q == yhi_q);

endmodule
`default_nettype wire

// File: rtl/laser_sched.sv
`default_nettype none
// ============================================================================
// Module : laser_sched
// Brief  : Alternating coordinate search for two circle centres on a 16x16
//          grid. Each round sweeps candidates for C1 then C2 through an
//          external coverage engine and keeps the strictly best one. Stops
//          on no round improvement, MAX_ITER rounds, or full coverage.
//          Option macro LASER_SCHED_WINDOW_EN: from round 2 on, each phase
//          sweeps only a +/-WIN_R window about that circle's centre.
// Rev    : 1.0  initial release
// ============================================================================
module laser_sched
  import laser_pkg::*;
#(
  parameter int MAX_ITER = 8,
  parameter int NUM_PTS  = 40
) (
  input  logic          CLK,
  input  logic          RST,
  laser_sched_if.master bus
);

  localparam int                ITER_W     = $clog2(MAX_ITER + 1);
  localparam logic [ITER_W-1:0] c_max_iter = ITER_W'(MAX_ITER);
  localparam logic [5:0]        c_num_pts  = 6'(NUM_PTS);
`ifdef LASER_SCHED_WINDOW_EN
  localparam logic              c_win_en   = 1'b1;
`else
  localparam logic              c_win_en   = 1'b0;
`endif

  state_t            state_q, state_d;
  logic              which_q, which_d;
  logic [5:0]        best_q, best_d;
  logic [5:0]        prev_q, prev_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  coord_t            c1x_q, c1x_d, c1y_q, c1y_d;
  coord_t            c2x_q, c2x_d, c2y_q, c2y_d;

  logic   gen_load, gen_step, gen_win, gen_last;
  coord_t gen_cx, gen_cy, cand_x, cand_y;

  laser_sweep_gen u_sweep (
    .clk    (CLK),
    .rst    (RST),
    .load_i (gen_load),
    .win_i  (gen_win),
    .step_i (gen_step),
    .cx_i   (gen_cx),
    .cy_i   (gen_cy),
    .x_o    (cand_x),
    .y_o    (cand_y),
    .last_o (gen_last)
  );

  // Next-state and datapath decisions. The best score is cleared at every
  // phase start so each phase picks the best position of its own circle
  // given the other; the C2-phase best is thus the round's final score.
  always_comb begin
    state_d  = state_q;
    which_d  = which_q;
    best_d   = best_q;
    prev_d   = prev_q;
    cnt_d    = cnt_q;
    iter_d   = iter_q;
    c1x_d    = c1x_q;
    c1y_d    = c1y_q;
    c2x_d    = c2x_q;
    c2y_d    = c2y_q;
    gen_load = 1'b0;
    gen_step = 1'b0;
    gen_win  = 1'b0;
    gen_cx   = c1x_q;
    gen_cy   = c1y_q;
    case (state_q)
      S_IDLE: begin
        if (bus.START) begin
          c1x_d    = coord_t'(4);
          c1y_d    = coord_t'(4);
          c2x_d    = coord_t'(11);
          c2y_d    = coord_t'(11);
          best_d   = '0;
          prev_d   = '0;
          iter_d   = '0;
          which_d  = 1'b0;
          gen_load = 1'b1;
          state_d  = S_SWEEP;
        end
      end
      S_SWEEP: begin
        if (bus.ACK) begin
          cnt_d   = bus.CNT;
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        if (cnt_q > best_q) begin
          best_d = cnt_q;
          if (which_q) begin
            c2x_d = cand_x;
            c2y_d = cand_y;
          end else begin
            c1x_d = cand_x;
            c1y_d = cand_y;
          end
        end
        if (cnt_q == c_num_pts) begin
          state_d = S_OUT;
        end else if (!gen_last) begin
          gen_step = 1'b1;
          state_d  = S_SWEEP;
        end else if (!which_q) begin
          // C1 phase finished: sweep C2 about its centre as it stands now.
          which_d  = 1'b1;
          best_d   = '0;
          gen_load = 1'b1;
          gen_win  = c_win_en && (iter_q != '0);
          gen_cx   = c2x_q;
          gen_cy   = c2y_q;
          state_d  = S_SWEEP;
        end else begin
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        iter_d = iter_q + 1'b1;
        if ((best_q <= prev_q) || (iter_d == c_max_iter)) begin
          state_d = S_OUT;
        end else begin
          prev_d   = best_q;
          best_d   = '0;
          which_d  = 1'b0;
          gen_load = 1'b1;
          gen_win  = c_win_en;
          state_d  = S_SWEEP;
        end
      end
      S_OUT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything, even mid-sweep.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      which_q <= 1'b0;
      best_q  <= '0;
      prev_q  <= '0;
      cnt_q   <= '0;
      iter_q  <= '0;
      c1x_q   <= '0;
      c1y_q   <= '0;
      c2x_q   <= '0;
      c2y_q   <= '0;
    end else begin
      state_q <= state_d;
      which_q <= which_d;
      best_q  <= best_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      iter_q  <= iter_d;
      c1x_q   <= c1x_d;
      c1y_q   <= c1y_d;
      c2x_q   <= c2x_d;
      c2y_q   <= c2y_d;
    end
  end

  assign bus.REQ    = (state_q == S_SWEEP);
  assign bus.CAND_X = cand_x;
  assign bus.CAND_Y = cand_y;
  assign bus.WHICH  = which_q;
  assign bus.C1X    = c1x_q;
  assign bus.C1Y    = c1y_q;
  assign bus.C2X    = c2x_q;
  assign bus.C2Y    = c2y_q;
  assign bus.BUSY   = (state_q != S_IDLE);
  assign bus.DONE   = (state_q == S_OUT);

endmodule
`default_nettype wire
